// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, register-zero index and forward-select encoding
package cpu_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/fwd_sel_unit.sv
// rtl/fwd_sel_unit.sv - per-operand hit detection and forward mux (ID_FORWARD_EN enables the forward mux)
module fwd_sel_unit
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] r_i,
  input  logic [DW-1:0] rf_data_i,
  input  logic          ex_we_i,
  input  logic [AW-1:0] ex_rd_i,
  input  logic [DW-1:0] ex_data_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_rd_i,
  input  logic [DW-1:0] mem_data_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  output fwd_sel_e      sel_o,
  output logic [DW-1:0] operand_o,
  output logic          any_hit_o
);

  localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

  logic          is_zero;
  logic          ex_hit;
  logic          mem_hit;
  logic          wb_hit;
  logic [DW-1:0] fwd_operand;

  // r0 is hardwired, so it can never match a producer
  assign is_zero   = (r_i == RZ);
  assign ex_hit    = ex_we_i  & (ex_rd_i  == r_i) & ~is_zero;
  assign mem_hit   = mem_we_i & (mem_rd_i == r_i) & ~is_zero;
  assign wb_hit    = wb_we_i  & (wb_rd_i  == r_i) & ~is_zero;
  assign any_hit_o = ex_hit | mem_hit | wb_hit;

  // youngest producer wins; WB is needed because the regfile is not write-through
  always_comb begin
    sel_o       = FWD_RF;
    fwd_operand = rf_data_i;
    if (ex_hit) begin
      sel_o       = FWD_EX;
      fwd_operand = ex_data_i;
    end else if (mem_hit) begin
      sel_o       = FWD_MEM;
      fwd_operand = mem_data_i;
    end else if (wb_hit) begin
      sel_o       = FWD_WB;
      fwd_operand = wb_data_i;
    end
    if (is_zero) begin
      fwd_operand = '0;
    end
  end

`ifdef ID_FORWARD_EN
  assign operand_o = fwd_operand;
`else
  // without forwarding the stage stalls on any hit, so the regfile value is always current
  assign operand_o = is_zero ? '0 : rf_data_i;
  wire unused_fwd_operand = ^fwd_operand;
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX operand resolve, hazard stall and EX register (ID_FORWARD_EN selects forwarding)
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          Valid_in,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  input  logic [DW-1:0] Qa,
  input  logic [DW-1:0] Qb,
  input  logic [AW-1:0] Rd_in,
  input  logic          Wreg_in,
  input  logic          Mem2reg_in,
  input  logic [DW-1:0] Ex_Result,
  input  logic [AW-1:0] M_Rd,
  input  logic          M_Wreg,
  input  logic [DW-1:0] M_Data,
  input  logic [AW-1:0] W_Rd,
  input  logic          W_We,
  input  logic [DW-1:0] W_D,
  input  logic          Flush,
  output logic [DW-1:0] Ea,
  output logic [DW-1:0] Eb,
  output logic [AW-1:0] E_Rd,
  output logic          E_Wreg,
  output logic          E_Mem2reg,
  output logic          E_Valid,
  output logic          Stall
);

  localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

  logic [DW-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          wreg_q, wreg_d, m2r_q, m2r_d, valid_q, valid_d;

  logic          ex_we;
  logic [DW-1:0] opa, opb;
  logic          hit_a, hit_b;
  fwd_sel_e      sel_a, sel_b;
  logic          stall;

  assign ex_we = valid_q & wreg_q;

  fwd_sel_unit #(.DW(DW), .AW(AW)) u_fwd_a (
    .r_i(Ra), .rf_data_i(Qa),
    .ex_we_i(ex_we), .ex_rd_i(rd_q), .ex_data_i(Ex_Result),
    .mem_we_i(M_Wreg), .mem_rd_i(M_Rd), .mem_data_i(M_Data),
    .wb_we_i(W_We), .wb_rd_i(W_Rd), .wb_data_i(W_D),
    .sel_o(sel_a), .operand_o(opa), .any_hit_o(hit_a)
  );

  fwd_sel_unit #(.DW(DW), .AW(AW)) u_fwd_b (
    .r_i(Rb), .rf_data_i(Qb),
    .ex_we_i(ex_we), .ex_rd_i(rd_q), .ex_data_i(Ex_Result),
    .mem_we_i(M_Wreg), .mem_rd_i(M_Rd), .mem_data_i(M_Data),
    .wb_we_i(W_We), .wb_rd_i(W_Rd), .wb_data_i(W_D),
    .sel_o(sel_b), .operand_o(opb), .any_hit_o(hit_b)
  );

  // select codes are informational here; the operands already carry the choice
  wire unused_sel = ^{sel_a, sel_b};

`ifdef ID_FORWARD_EN
  // only a load in EX cannot be forwarded yet; one bubble moves it to MEM
  assign stall = Valid_in & valid_q & m2r_q & wreg_q & (rd_q != RZ)
               & ((rd_q == Ra) | (rd_q == Rb)) & ~Flush;
  wire unused_hits = hit_a ^ hit_b;
`else
  // wait until every in-flight producer has retired through WB
  assign stall = Valid_in & ~Flush & (hit_a | hit_b);
`endif

  assign Stall = stall;

  // next EX contents: bubble on flush or stall, otherwise capture the ID instruction
  always_comb begin
    ea_d    = '0;
    eb_d    = '0;
    rd_d    = '0;
    wreg_d  = 1'b0;
    m2r_d   = 1'b0;
    valid_d = 1'b0;
    if (!(Flush | stall)) begin
      ea_d    = opa;
      eb_d    = opb;
      rd_d    = Rd_in;
      wreg_d  = Wreg_in & Valid_in;
      m2r_d   = Mem2reg_in & Valid_in;
      valid_d = Valid_in;
    end
  end

  // EX pipeline register with synchronous clear
  always_ff @(posedge Clk) begin
    if (Clr) begin
      ea_q    <= '0;
      eb_q    <= '0;
      rd_q    <= '0;
      wreg_q  <= 1'b0;
      m2r_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      rd_q    <= rd_d;
      wreg_q  <= wreg_d;
      m2r_q   <= m2r_d;
      valid_q <= valid_d;
    end
  end

  assign Ea        = ea_q;
  assign Eb        = eb_q;
  assign E_Rd      = rd_q;
  assign E_Wreg    = wreg_q;
  assign E_Mem2reg = m2r_q;
  assign E_Valid   = valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage (both ID_FORWARD_EN builds)
module tb_id_ex_operand_stage;

`ifdef ID_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Clr, Valid_in, Wreg_in, Mem2reg_in, M_Wreg, W_We, Flush;
  logic [4:0]  Ra, Rb, Rd_in, M_Rd, W_Rd;
  logic [31:0] Qa, Qb, Ex_Result, M_Data, W_D;
  logic [31:0] Ea, Eb;
  logic [4:0]  E_Rd;
  logic        E_Wreg, E_Mem2reg, E_Valid, Stall;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_ea, m_eb;
  logic [4:0]  m_rd;
  logic        m_wreg, m_m2r, m_valid;

  id_ex_operand_stage dut (
    .Clk(Clk), .Clr(Clr), .Valid_in(Valid_in), .Ra(Ra), .Rb(Rb), .Qa(Qa), .Qb(Qb),
    .Rd_in(Rd_in), .Wreg_in(Wreg_in), .Mem2reg_in(Mem2reg_in), .Ex_Result(Ex_Result),
    .M_Rd(M_Rd), .M_Wreg(M_Wreg), .M_Data(M_Data), .W_Rd(W_Rd), .W_We(W_We), .W_D(W_D),
    .Flush(Flush), .Ea(Ea), .Eb(Eb), .E_Rd(E_Rd), .E_Wreg(E_Wreg), .E_Mem2reg(E_Mem2reg),
    .E_Valid(E_Valid), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  // does some in-flight instruction (EX, MEM or WB) still owe register r?
  function automatic bit pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (m_valid && m_wreg && m_rd == r) || (M_Wreg && M_Rd == r) || (W_We && W_Rd == r);
  endfunction

  // value the instruction should see: newest in-flight producer, else the regfile
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] q);
    if (r == 5'd0) return 32'd0;
    if (!FWD_ON) return q;
    if (m_valid && m_wreg && m_rd == r) return Ex_Result;
    if (M_Wreg && M_Rd == r) return M_Data;
    if (W_We && W_Rd == r) return W_D;
    return q;
  endfunction

  function automatic bit model_stall();
    if (!Valid_in || Flush) return 1'b0;
    if (FWD_ON)
      return m_valid && m_m2r && m_wreg && m_rd != 5'd0 && (m_rd == Ra || m_rd == Rb);
    return pending(Ra) || pending(Rb);
  endfunction

  task automatic idle_inputs();
    Clr = 0; Valid_in = 0; Wreg_in = 0; Mem2reg_in = 0; M_Wreg = 0; W_We = 0; Flush = 0;
    Ra = 0; Rb = 0; Rd_in = 0; M_Rd = 0; W_Rd = 0;
    Qa = 0; Qb = 0; Ex_Result = 0; M_Data = 0; W_D = 0;
  endtask

  // clock one edge and move the reference EX register accordingly
  task automatic advance();
    logic [31:0] na, nb; logic [4:0] nrd; logic nw, nm, nv;
    na = 0; nb = 0; nrd = 0; nw = 0; nm = 0; nv = 0;
    if (!Clr && !Flush && !model_stall()) begin
      na = operand(Ra, Qa); nb = operand(Rb, Qb); nrd = Rd_in;
      nw = Wreg_in && Valid_in; nm = Mem2reg_in && Valid_in; nv = Valid_in;
    end
    @(posedge Clk); #1;
    m_ea = na; m_eb = nb; m_rd = nrd; m_wreg = nw; m_m2r = nm; m_valid = nv;
  endtask

  task automatic issue(input logic [4:0] rd, input bit ld);
    idle_inputs(); Valid_in = 1; Rd_in = rd; Wreg_in = 1; Mem2reg_in = ld;
    advance();
  endtask

  task automatic test_reset();
    Clr = 1; Valid_in = 1; Ra = 3; Rb = 4; Qa = 32'hAAAA; Qb = 32'hBBBB; Rd_in = 7;
    Wreg_in = 1; Mem2reg_in = 1; Ex_Result = 32'h1; M_Rd = 3; M_Wreg = 1; M_Data = 32'h2;
    W_Rd = 4; W_We = 1; W_D = 32'h3; Flush = 1;
    advance();
    idle_inputs(); #1;
    total++; if (Ea !== 0) begin bad++; $display("FAIL reset_ea got=%h want=0", Ea); end
    total++; if (Eb !== 0) begin bad++; $display("FAIL reset_eb got=%h want=0", Eb); end
    total++; if (E_Rd !== 0) begin bad++; $display("FAIL reset_rd got=%h want=0", E_Rd); end
    total++; if ({E_Wreg, E_Mem2reg, E_Valid} !== 3'b000) begin bad++;
      $display("FAIL reset_ctl got=%b want=000", {E_Wreg, E_Mem2reg, E_Valid}); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", Stall); end
  endtask

  task automatic test_ex_fwd();
    int stalls = 0;
    issue(5'd3, 1'b0);
    idle_inputs(); Valid_in = 1; Ra = 3; Qa = 32'h11; Ex_Result = 32'h55;
    for (int i = 0; i < 6 && (i == 0 || stalls > 0); i++) begin
      #1;
      if (Stall !== 1'b1) break;
      stalls++;
      advance();
      // walk the producer down the pipe: EX -> MEM -> WB -> regfile
      M_Wreg = (stalls == 1); M_Rd = 3; M_Data = 32'h55;
      W_We = (stalls == 2); W_Rd = 3; W_D = 32'h55;
      if (stalls == 3) Qa = 32'h55;
    end
    total++; if (stalls != (FWD_ON ? 0 : 3)) begin bad++;
      $display("FAIL ex_fwd_stalls got=%0d want=%0d", stalls, FWD_ON ? 0 : 3); end
    advance();
    total++; if (Ea !== 32'h55) begin bad++; $display("FAIL ex_fwd_ea got=%h want=00000055", Ea); end
    total++; if (E_Valid !== 1'b1) begin bad++; $display("FAIL ex_fwd_valid got=%b want=1", E_Valid); end
  endtask

  task automatic test_priority();
    logic [31:0] want [3];
    want[0] = FWD_ON ? 32'h55 : 32'h0;
    want[1] = FWD_ON ? 32'h66 : 32'h0;
    want[2] = FWD_ON ? 32'h77 : 32'h0;
    issue(5'd3, 1'b0);
    idle_inputs(); Valid_in = 1; Ra = 3; Qa = 32'h11;
    Ex_Result = 32'h55; M_Rd = 3; M_Wreg = 1; M_Data = 32'h66; W_Rd = 3; W_We = 1; W_D = 32'h77;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) M_Wreg = 0;
      #1;
      total++; if (Stall !== !FWD_ON) begin bad++;
        $display("FAIL prio_stall%0d got=%b want=%b", i, Stall, !FWD_ON); end
      advance();
      total++; if (Ea !== want[i]) begin bad++;
        $display("FAIL prio_ea%0d got=%h want=%h", i, Ea, want[i]); end
    end
  endtask

  task automatic test_load_use();
    issue(5'd5, 1'b1);
    idle_inputs(); Valid_in = 1; Rb = 5; Qb = 32'h99; Rd_in = 6; Wreg_in = 1;
    #1;
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL lu_stall1 got=%b want=1", Stall); end
    advance();
    total++; if (E_Valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b want=0", E_Valid); end
    M_Rd = 5; M_Wreg = 1; M_Data = 32'hDEAD_BEEF;
    #1;
    total++; if (Stall !== !FWD_ON) begin bad++; $display("FAIL lu_stall2 got=%b want=%b", Stall, !FWD_ON); end
    advance();
    total++; if (Eb !== (FWD_ON ? 32'hDEAD_BEEF : 32'h0)) begin bad++;
      $display("FAIL lu_eb got=%h want=%h", Eb, FWD_ON ? 32'hDEAD_BEEF : 32'h0); end
  endtask

  task automatic test_r0();
    issue(5'd0, 1'b0);
    idle_inputs(); Valid_in = 1; Ra = 0; Qa = 32'hFFFF; Ex_Result = 32'h1234; Rd_in = 2;
    #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b want=0", Stall); end
    advance();
    total++; if (Ea !== 32'h0) begin bad++; $display("FAIL r0_ea got=%h want=0", Ea); end
  endtask

  task automatic test_flush();
    issue(5'd5, 1'b1);
    idle_inputs(); Valid_in = 1; Rb = 5; Qb = 32'h42; Rd_in = 9; Wreg_in = 1; Flush = 1;
    #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", Stall); end
    advance();
    total++; if ({E_Valid, E_Wreg, E_Rd, Eb} !== 39'd0) begin bad++;
      $display("FAIL flush_bubble got v=%b w=%b rd=%h eb=%h want all 0", E_Valid, E_Wreg, E_Rd, Eb); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      Clr = ($urandom_range(0, 49) == 0); Valid_in = $urandom_range(0, 3) != 0;
      Flush = ($urandom_range(0, 9) == 0);
      Ra = 5'($urandom_range(0, 3)); Rb = 5'($urandom_range(0, 3)); Rd_in = 5'($urandom_range(0, 3));
      Wreg_in = $urandom_range(0, 1); Mem2reg_in = $urandom_range(0, 1);
      M_Rd = 5'($urandom_range(0, 3)); M_Wreg = $urandom_range(0, 1);
      W_Rd = 5'($urandom_range(0, 3)); W_We = $urandom_range(0, 1);
      Qa = $urandom; Qb = $urandom; Ex_Result = $urandom; M_Data = $urandom; W_D = $urandom;
      #1;
      total++; if (Stall !== model_stall()) begin bad++;
        $display("FAIL rand_stall n=%0d got=%b want=%b", n, Stall, model_stall()); end
      advance();
      total++;
      if ({Ea, Eb, E_Rd, E_Wreg, E_Mem2reg, E_Valid} !== {m_ea, m_eb, m_rd, m_wreg, m_m2r, m_valid}) begin
        bad++;
        $display("FAIL rand_out n=%0d got=%h/%h/%h/%b%b%b want=%h/%h/%h/%b%b%b", n,
                 Ea, Eb, E_Rd, E_Wreg, E_Mem2reg, E_Valid, m_ea, m_eb, m_rd, m_wreg, m_m2r, m_valid);
      end
    end
  endtask

  initial begin
    m_ea = 0; m_eb = 0; m_rd = 0; m_wreg = 0; m_m2r = 0; m_valid = 0;
    idle_inputs();
    @(negedge Clk);
    test_reset();
    test_ex_fwd();
    test_priority();
    test_load_use();
    test_r0();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
